// File: rtl/leaf_stage_sequencer.sv
// leaf_stage_sequencer: launches each unmasked child in index order with a
// one-cycle go pulse and waits for that child's done before moving on.
// Optional per-child timeout (counter, err, err_idx) is compiled in when
// SEQ_TIMEOUT_EN is defined; without it err/err_idx are tied low and WAIT
// exits only on child_done.
module leaf_stage_sequencer #(
  parameter int NUM_CHILDREN = 15,
  parameter int TIMER_W      = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic [NUM_CHILDREN-1:0]                child_mask,
  input  logic [TIMER_W-1:0]                     timeout_cycles,
  output logic [NUM_CHILDREN-1:0]                child_go,
  input  logic [NUM_CHILDREN-1:0]                child_done,
  output logic                                   busy,
  output logic                                   done,
  output logic [$clog2(NUM_CHILDREN+1)-1:0]      cur_idx,
  output logic                                   err,
  output logic [$clog2(NUM_CHILDREN+1)-1:0]      err_idx
);

  localparam int IDX_W = $clog2(NUM_CHILDREN + 1);
  // The index register can hold NUM_CHILDREN itself, so per-child vectors are
  // padded to the full index range to keep every dynamic select in bounds.
  localparam int PAD_W = (1 << IDX_W) - NUM_CHILDREN;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_LAUNCH,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                  r_state, w_state_next;
  logic [IDX_W-1:0]        r_idx, w_idx_next;
  logic [NUM_CHILDREN-1:0] r_mask, w_mask_next;

  logic [(1<<IDX_W)-1:0]   w_mask_ext;
  logic [(1<<IDX_W)-1:0]   w_done_ext;
  logic [IDX_W-1:0]        w_idx_inc;
  logic                    w_idx_end;

  assign w_mask_ext = {{PAD_W{1'b1}}, r_mask};
  assign w_done_ext = {{PAD_W{1'b0}}, child_done};
  assign w_idx_inc  = r_idx + 1'b1;
  assign w_idx_end  = (r_idx == IDX_W'(NUM_CHILDREN));

`ifdef SEQ_TIMEOUT_EN
  logic [TIMER_W-1:0]      r_timer, w_timer_next;
  logic [TIMER_W-1:0]      r_limit, w_limit_next;
  logic                    r_err, w_err_next;
  logic [IDX_W-1:0]        r_err_idx, w_err_idx_next;
  logic                    w_expired;

  assign w_expired = (r_limit != '0) && (r_timer == r_limit - 1'b1);
`else
  // Timeout limit has no consumer in this build.
  logic w_unused_timeout;
  assign w_unused_timeout = ^timeout_cycles;
`endif

  // Next-state and datapath update; child_done takes priority over expiry.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_mask_next  = r_mask;
`ifdef SEQ_TIMEOUT_EN
    w_timer_next   = r_timer;
    w_limit_next   = r_limit;
    w_err_next     = r_err;
    w_err_idx_next = r_err_idx;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_CHECK;
          w_mask_next  = child_mask;
          w_idx_next   = '0;
`ifdef SEQ_TIMEOUT_EN
          w_limit_next = timeout_cycles;
          w_err_next   = 1'b0;
`endif
        end
      end
      S_CHECK: begin
        if (w_idx_end) begin
          w_state_next = S_DONE;
        end else if (w_mask_ext[r_idx]) begin
          w_idx_next = w_idx_inc;
        end else begin
          w_state_next = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
`ifdef SEQ_TIMEOUT_EN
        w_timer_next = '0;
`endif
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_done_ext[r_idx]) begin
          w_idx_next   = w_idx_inc;
          w_state_next = S_CHECK;
        end
`ifdef SEQ_TIMEOUT_EN
        else if (w_expired) begin
          w_err_next     = 1'b1;
          w_err_idx_next = r_idx;
          w_idx_next     = w_idx_inc;
          w_state_next   = S_CHECK;
        end else begin
          w_timer_next = r_timer + 1'b1;
        end
`endif
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any sequence in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_mask  <= '0;
`ifdef SEQ_TIMEOUT_EN
      r_timer   <= '0;
      r_limit   <= '0;
      r_err     <= 1'b0;
      r_err_idx <= '0;
`endif
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_mask  <= w_mask_next;
`ifdef SEQ_TIMEOUT_EN
      r_timer   <= w_timer_next;
      r_limit   <= w_limit_next;
      r_err     <= w_err_next;
      r_err_idx <= w_err_idx_next;
`endif
    end
  end

  // Go pulses are decoded from registered state and index only.
  generate
    for (genvar gi = 0; gi < NUM_CHILDREN; gi++) begin : g_go
      assign child_go[gi] = (r_state == S_LAUNCH) && (r_idx == IDX_W'(gi));
    end
  endgenerate

  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE);
  assign cur_idx = r_idx;

`ifdef SEQ_TIMEOUT_EN
  assign err     = r_err;
  assign err_idx = r_err_idx;
`else
  assign err     = 1'b0;
  assign err_idx = '0;
`endif

endmodule
